// File: rtl/weight_preloader_if.sv
// Weight-row handshake and MAC preload bus shared by the weight preloader
// and its producer and consumer. The master modport is the side that supplies
// rows and grants swaps. The slave modport is the preloader itself.
interface weight_preloader_if #(
  parameter int MATRIX_WIDTH = 8,
  parameter int BYTE_WIDTH   = 8
);
  logic                                    w_valid;
  logic                                    w_ready;
  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]      w_data;
  logic                                    w_signed;
  logic                                    w_last;
  logic [MATRIX_WIDTH*(BYTE_WIDTH+1)-1:0]  weight_out;
  logic [MATRIX_WIDTH-1:0]                 preload_weight;
  logic                                    load_weight;
  logic                                    swap_req;
  logic                                    swap_ack;
  logic                                    busy;

  modport master (
    output w_valid, w_data, w_signed, w_last, swap_ack,
    input  w_ready, weight_out, preload_weight, load_weight, swap_req, busy
  );

  modport slave (
    input  w_valid, w_data, w_signed, w_last, swap_ack,
    output w_ready, weight_out, preload_weight, load_weight, swap_req, busy
  );
endinterface

// File: rtl/weight_preloader.sv
// Weight preloader: accepts one weight row per beat, extends each byte to
// BYTE_WIDTH+1 bits, and preloads the MAC array row by row. A short tile,
// marked by w_last, is padded with zero rows. When all rows are loaded, the
// block requests a preweight-to-weight swap.
// Optional feature: define WEIGHT_PRELOADER_TILE_COUNT_EN to add a 16-bit
// tile_count output that counts load_weight pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for row 0 of a new tile; the row counter is 0
// FILL      | accepting rows 1..MATRIX_WIDTH-1 from the producer
// ZERO_FILL | padding the rows that follow a short tile with zero weights
// WAIT_SWAP | tile complete, swap_req held until swap_ack
// SWAP      | one-cycle load_weight broadcast, then back to IDLE
module weight_preloader #(
  parameter int MATRIX_WIDTH = 8,
  parameter int BYTE_WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  weight_preloader_if.slave  bus
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
  ,
  output logic [15:0]        tile_count
`endif
);

  localparam int EXT_WIDTH = BYTE_WIDTH + 1;
  localparam int ROW_WIDTH = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam logic [ROW_WIDTH-1:0]    LAST_ROW = ROW_WIDTH'(MATRIX_WIDTH - 1);
  localparam logic [MATRIX_WIDTH-1:0] ROW_ONE  = MATRIX_WIDTH'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FILL      = 3'd1;
  localparam logic [2:0] ZERO_FILL = 3'd2;
  localparam logic [2:0] WAIT_SWAP = 3'd3;
  localparam logic [2:0] SWAP      = 3'd4;

  logic [2:0]                            state_q;
  logic [ROW_WIDTH-1:0]                  row_q;
  logic [MATRIX_WIDTH*EXT_WIDTH-1:0]     weight_q;
  logic [MATRIX_WIDTH-1:0]               preload_q;
  logic [MATRIX_WIDTH*EXT_WIDTH-1:0]     ext_row;
  logic                                  ready;
  logic                                  accept;

  assign ready  = (state_q == IDLE) || (state_q == FILL);
  assign accept = bus.w_valid && ready;

  // Widen each column byte by one bit, copying the sign bit only for signed rows.
  always_comb begin
    ext_row = '0;
    for (int c = 0; c < MATRIX_WIDTH; c++) begin
      ext_row[c*EXT_WIDTH +: EXT_WIDTH] =
        {bus.w_signed & bus.w_data[c*BYTE_WIDTH + BYTE_WIDTH - 1],
         bus.w_data[c*BYTE_WIDTH +: BYTE_WIDTH]};
    end
  end

  // Sequencer: row capture, zero padding and swap handshake. preload_q is a
  // single-cycle strobe. weight_q holds its value between preloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      weight_q  <= '0;
      preload_q <= '0;
    end else begin
      preload_q <= '0;
      case (state_q)
        // row_q is always 0 in IDLE, so a beat accepted there lands on row 0
        IDLE, FILL: begin
          if (accept) begin
            weight_q  <= ext_row;
            preload_q <= ROW_ONE << row_q;
            if (row_q == LAST_ROW) begin
              state_q <= WAIT_SWAP;
            end else begin
              row_q   <= row_q + ROW_WIDTH'(1);
              state_q <= bus.w_last ? ZERO_FILL : FILL;
            end
          end
        end
        ZERO_FILL: begin
          weight_q  <= '0;
          preload_q <= ROW_ONE << row_q;
          if (row_q == LAST_ROW) begin
            state_q <= WAIT_SWAP;
          end else begin
            row_q <= row_q + ROW_WIDTH'(1);
          end
        end
        WAIT_SWAP: begin
          if (bus.swap_ack) begin
            state_q <= SWAP;
          end
        end
        SWAP: begin
          row_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          row_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.w_ready        = ready;
  assign bus.weight_out     = weight_q;
  assign bus.preload_weight = preload_q;
  assign bus.load_weight    = (state_q == SWAP);
  assign bus.swap_req       = (state_q == WAIT_SWAP);
  assign bus.busy           = (state_q != IDLE);

`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
  logic [15:0] tile_cnt_q;

  // Count completed swaps. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt_q <= '0;
    end else if (state_q == SWAP) begin
      tile_cnt_q <= tile_cnt_q + 16'd1;
    end
  end

  assign tile_count = tile_cnt_q;
`endif

endmodule

// File: tb/tb_weight_preloader.sv
// Directed bench for weight_preloader. It covers full tiles, signed and
// unsigned extension, zero padding after w_last, a delayed swap_ack, bubbles,
// beats ignored while w_ready is low, and a reset in the middle of a tile.
// Define WEIGHT_PRELOADER_TILE_COUNT_EN to also exercise tile_count.
module tb_weight_preloader;
  localparam int MW = 8;
  localparam int BW = 8;
  localparam int EW = BW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_preloader_if #(.MATRIX_WIDTH(MW), .BYTE_WIDTH(BW)) bus ();
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
  logic [15:0] tile_count;
`endif

  weight_preloader #(.MATRIX_WIDTH(MW), .BYTE_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
    ,
    .tile_count (tile_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int tiles  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW*EW-1:0] ext(input logic [MW*BW-1:0] d, input logic s);
    logic [BW-1:0] b;
    ext = '0;
    for (int c = 0; c < MW; c++) begin
      b = d[c*BW +: BW];
      ext[c*EW +: EW] = {s & b[BW-1], b};
    end
  endfunction

  // Drive nrows beats starting at row 0. w_last is raised on row last_at
  // (-1 = never). Each preload is checked on the following negedge.
  task automatic fill(input logic [63:0] base, input logic s, input int nrows,
                      input int last_at, input bit vary, input bit bubble);
    logic [63:0]        d;
    logic [MW*EW-1:0]   held;
    for (int r = 0; r < nrows; r++) begin
      d = vary ? (base ^ {8{8'(r*37)}}) : base;
      chk("w_ready_fill", bus.w_ready, 1);
      bus.w_valid  = 1'b1;
      bus.w_data   = d;
      bus.w_signed = s;
      bus.w_last   = (r == last_at);
      @(negedge clk);
      held = ext(d, s);
      chk("preload_row", bus.preload_weight, 8'(1) << r);
      chk("weight_row", bus.weight_out, held);
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
      if (bubble && r < nrows - 1) begin
        @(negedge clk);
        chk("bubble_preload", bus.preload_weight, 0);
        chk("bubble_hold", bus.weight_out, held);
      end
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  // Called on the first WAIT_SWAP negedge. The bench withholds swap_ack for
  // `hold` cycles while offering beats that must be ignored.
  task automatic do_swap(input int hold);
    chk("swap_req_enter", bus.swap_req, 1);
    chk("busy_wait", bus.busy, 1);
    for (int i = 0; i < hold; i++) begin
      bus.w_valid  = 1'b1;
      bus.w_data   = 64'hDEAD_BEEF_0BAD_F00D;
      bus.swap_ack = 1'b0;
      @(negedge clk);
      chk("swap_req_hold", bus.swap_req, 1);
      chk("no_load_hold", bus.load_weight, 0);
      chk("ignored_beat", bus.preload_weight, 0);
    end
    bus.w_valid  = 1'b0;
    bus.swap_ack = 1'b1;
    @(negedge clk);
    bus.swap_ack = 1'b0;
    tiles++;
    chk("swap_req_drop", bus.swap_req, 0);
    chk("load_pulse", bus.load_weight, 1);
    @(negedge clk);
    chk("load_single", bus.load_weight, 0);
    chk("w_ready_after", bus.w_ready, 1);
    chk("busy_after", bus.busy, 0);
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
    chk("tile_count", tile_count, 16'(tiles));
`endif
  endtask

  task automatic zero_pad(input int first_row);
    chk("w_ready_zf", bus.w_ready, 0);
    for (int r = first_row; r < MW; r++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("zf_preload", bus.preload_weight, 8'(1) << r);
      chk("zf_zero", bus.weight_out, 0);
      chk("zf_w_ready", bus.w_ready, 0);
      chk("zf_swap_req", bus.swap_req, (r == MW - 1) ? 1 : 0);
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_weight", bus.weight_out, 0);
    chk("rst_preload", bus.preload_weight, 0);
    chk("rst_load", bus.load_weight, 0);
    chk("rst_swap_req", bus.swap_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_w_ready", bus.w_ready, 1);
  endtask

  initial begin
    bus.w_valid  = 1'b0;
    bus.w_data   = '0;
    bus.w_signed = 1'b0;
    bus.w_last   = 1'b0;
    bus.swap_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state();
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
    chk("rst_tile_count", tile_count, 0);
`endif
    rst = 1'b0;

    // A swap_ack raised while IDLE must have no effect.
    bus.swap_ack = 1'b1;
    @(negedge clk);
    bus.swap_ack = 1'b0;
    chk("idle_ack_busy", bus.busy, 0);
    chk("idle_ack_load", bus.load_weight, 0);

    // Signed 0x81 tile, back-to-back beats.
    fill({8{8'h81}}, 1'b1, 8, -1, 1'b0, 1'b0);
    chk("signed_81", bus.weight_out, {8{9'h181}});
    do_swap(0);

    // The same tile unsigned. swap_ack is held off for 10 cycles.
    fill({8{8'h81}}, 1'b0, 8, -1, 1'b0, 1'b0);
    chk("unsigned_81", bus.weight_out, {8{9'h081}});
    do_swap(10);

    // Short tile: w_last on row 2, with bubbles. Rows 3..7 are zero-padded.
    fill(64'h7F80_01FE_3C00_FF55, 1'b1, 3, 2, 1'b1, 1'b1);
    zero_pad(3);
    do_swap(0);

    // Reset after row 4. The partial tile is dropped and no swap occurs.
    fill(64'h1234_5678_9ABC_DEF0, 1'b1, 5, -1, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_load", bus.load_weight, 0);
      chk("post_rst_busy", bus.busy, 0);
    end
`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
    tiles = 0;
    chk("post_rst_count", tile_count, 0);
`endif

    // The next tile starts again at row 0.
    fill(64'hA5C3_0F81_7E42_19E6, 1'b1, 8, -1, 1'b1, 1'b1);
    do_swap(3);
    fill(64'h0102_0408_1020_4080, 1'b0, 8, -1, 1'b1, 1'b0);
    do_swap(1);
    fill(64'hFF00_FF00_8877_6655, 1'b1, 4, 3, 1'b1, 1'b0);
    zero_pad(4);
    do_swap(0);

`ifdef WEIGHT_PRELOADER_TILE_COUNT_EN
    chk("three_tiles", tile_count, 3);
    force dut.tile_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.tile_cnt_q;
    @(negedge clk);
    chk("forced_max", tile_count, 16'hFFFF);
    tiles = 65535;
    fill({8{8'h81}}, 1'b1, 8, -1, 1'b0, 1'b0);
    do_swap(0);
    chk("wrap_zero", tile_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_preloader.md
WEIGHT_PRELOADER -- requirements
Module: weight_preloader

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 8, meaning rows/columns of the MAC array fed.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, meaning raw weight width; the extended weight width is BYTE_WIDTH+1.
REQ-003 SHALL have ports as follows; reset rst, synchronous, active-high; clock clk:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  beat accepted when w_valid && w_ready
- w_data  in  MATRIX_WIDTH*BYTE_WIDTH  one weight row; column c occupies bits [c*BYTE_WIDTH +: BYTE_WIDTH]
- w_signed  in  1  sign-extend (1) or zero-extend (0) the row's bytes
- w_last  in  1  marks the final supplied row of a tile
- weight_out  out  MATRIX_WIDTH*(BYTE_WIDTH+1)  extended row to the MAC weight_in ports
- preload_weight  out  MATRIX_WIDTH  one-hot row select for MAC preload
- load_weight  out  1  broadcast preweight-to-weight transfer pulse
- swap_req  out  1  tile fully preloaded, requesting transfer
- swap_ack  in  1  array controller grants transfer
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 SHALL implement the states IDLE, FILL, ZERO_FILL, WAIT_SWAP and SWAP, plus a row counter of width clog2(MATRIX_WIDTH).
REQ-005 SHALL drive w_ready=1 only in IDLE and FILL.
REQ-006 SHALL, on the first accepted beat in IDLE, enter FILL and treat that beat as row 0.
REQ-007 SHALL, for a beat accepted at cycle t for row r, drive weight_out=extended w_data and preload_weight=(1<<r) at t+1 for exactly one cycle, with all outputs registered.
REQ-008 SHALL drive preload_weight=0 and hold weight_out at its last value in any cycle with no preload.
REQ-009 SHALL, on an accepted beat with r=MATRIX_WIDTH-1, enter WAIT_SWAP regardless of w_last.
REQ-010 SHALL, on an accepted beat with w_last=1 and r<MATRIX_WIDTH-1, enter ZERO_FILL.
REQ-011 SHALL, in ZERO_FILL, preload rows r+1..MATRIX_WIDTH-1 with all-zero weights, one row per cycle in ascending order, then enter WAIT_SWAP.
REQ-012 SHALL, in WAIT_SWAP, assert swap_req until a cycle with swap_ack=1, then enter SWAP with swap_req deasserted the next cycle.
REQ-013 SHALL, in SWAP, assert load_weight for exactly one cycle, clear the row counter, and return to IDLE.
REQ-014 SHALL ignore swap_ack in every state other than WAIT_SWAP.
REQ-015 SHALL ignore w_valid while w_ready=0, and no beat is consumed.
REQ-016 SHALL sign-extend each byte from bit BYTE_WIDTH-1 when w_signed=1, and zero-extend it otherwise.
REQ-017 SHALL pass every bubble cycle (w_valid=0 in FILL) without advancing the row counter.

Reset
REQ-018 SHALL, on rst at any cycle including mid-tile, enter IDLE, clear the row counter, and drive weight_out=0, preload_weight=0, load_weight=0, swap_req=0, busy=0 and w_ready=1 from the next cycle.
REQ-019 SHALL discard a partially loaded tile on reset, with no load_weight issued for it.

Configuration
REQ-020 SHALL, when macro WEIGHT_PRELOADER_TILE_COUNT_EN is defined, add output tile_count (16 bits, reset 0) that increments by 1 at each load_weight pulse and wraps from 65535 to 0.
REQ-021 SHALL, when WEIGHT_PRELOADER_TILE_COUNT_EN is undefined, have no tile_count port or counter, with all other behaviour identical.

Verification
REQ-022 SHALL cover: 8 back-to-back beats, row c byte = 8'h81, w_signed=1 -> preload_weight 01,02,...,80 on consecutive cycles; weight_out columns = 9'h181; swap_req follows.
REQ-023 SHALL cover: the same tile with w_signed=0 -> weight_out columns = 9'h081.
REQ-024 SHALL cover: w_last on row 2 -> rows 3..7 preloaded with 0 on 5 consecutive cycles, w_ready=0 throughout, then swap_req=1.
REQ-025 SHALL cover: swap_ack held 0 for 10 cycles then 1 -> swap_req stays high 10 cycles; load_weight pulses once; w_ready=1 the cycle after.
REQ-026 SHALL cover: rst asserted after row 4 -> no load_weight; all outputs 0 and w_ready=1; the next tile starts at row 0.
REQ-027 SHALL cover: with WEIGHT_PRELOADER_TILE_COUNT_EN, 3 complete tiles -> tile_count=3; forced to 65535, one tile -> 0.
